// File: rtl/mac_result_drain.sv
// Drains a captured 4-lane accumulator result as 4 handshaked beats, lane 0 first.
// out_last marks result boundaries according to the mode latched at capture time.
module mac_result_drain #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_ACC_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      cap,
    input  logic [MAC_ACC_WIDTH-1:0]  in0,
    input  logic [MAC_ACC_WIDTH-1:0]  in1,
    input  logic [MAC_ACC_WIDTH-1:0]  in2,
    input  logic [MAC_ACC_WIDTH-1:0]  in3,
    output logic                      cap_ready,
    output logic [MAC_ACC_WIDTH-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [1:0]                out_idx,
    output logic                      ovf,
    input  logic                      clr_ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                           state_q, state_d;
    logic [1:0]                       cnt_q, cnt_d;
    logic [1:0]                       mode_q, mode_d;
    logic [3:0][MAC_ACC_WIDTH-1:0]    lane_q, lane_d;
    logic                             ovf_q, ovf_d;

    if (MAC_CONF_WIDTH > 2) begin : g_cfg_hi
        logic unused_cfg;
        assign unused_cfg = ^cfg[MAC_CONF_WIDTH-1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            lane_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            lane_q  <= lane_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        lane_d    = lane_q;
        ovf_d     = ovf_q;
        out_valid = 1'b0;
        out_idx   = '0;
        out_data  = '0;
        out_last  = 1'b0;
        cap_ready = 1'b0;

        if (state_q == SEND) begin
            out_valid = 1'b1;
            out_idx   = cnt_q;
            out_data  = lane_q[cnt_q];
            unique case (mode_q)
                2'b00:   out_last = 1'b1;
                2'b10:   out_last = (cnt_q == 2'd3);
                default: out_last = cnt_q[0];
            endcase
            cap_ready = (cnt_q == 2'd3) && out_ready;
            if (out_ready) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
        end else begin
            cap_ready = 1'b1;
        end

        // A capture on the final-beat transfer overrides the return to IDLE.
        if (cap && cap_ready) begin
            state_d = SEND;
            cnt_d   = '0;
            mode_d  = cfg[1:0];
            lane_d  = {in3, in2, in1, in0};
        end

        if (cap && !cap_ready) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: directed scenarios then random traffic, checked
// against a queue of expected beats built from the capture/handshake rules.
module tb_mac_result_drain;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    cfg;
    logic          cap;
    logic [W-1:0]  in0, in1, in2, in3;
    logic          cap_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [1:0]    out_idx;
    logic          ovf;
    logic          clr_ovf;

    mac_result_drain #(.MAC_CONF_WIDTH(3), .MAC_ACC_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cfg(cfg), .cap(cap),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .cap_ready(cap_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_idx(out_idx),
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   i;
        logic         l;
    } beat_t;

    beat_t q[$];
    logic  m_ovf;
    int    checks   = 0;
    int    failures = 0;

    function automatic logic last_of(input logic [1:0] mode, input int unsigned k);
        if (mode == 2'b00) return 1'b1;
        if (mode == 2'b10) return k == 3;
        return (k % 2) == 1;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs before the edge, then advance the model.
    task automatic step(input logic c, input logic [2:0] cf,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e, input logic [W-1:0] f,
                        input logic rdy, input logic clr);
        logic exp_rdy;
        logic [W-1:0] lanes[4];
        cap = c; cfg = cf; in0 = a; in1 = b; in2 = e; in3 = f;
        out_ready = rdy; clr_ovf = clr;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && rdy);
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_idx", W'(out_idx), W'(q[0].i));
            chk("out_last", W'(out_last), W'(q[0].l));
        end else begin
            chk("idle_data", out_data, '0);
            chk("idle_idx", W'(out_idx), '0);
            chk("idle_last", W'(out_last), '0);
        end
        chk("cap_ready", W'(cap_ready), W'(exp_rdy));
        chk("ovf", W'(ovf), W'(m_ovf));
        @(posedge clk);
        if (q.size() > 0 && rdy) void'(q.pop_front());
        lanes = '{a, b, e, f};
        if (c && exp_rdy) begin
            for (int k = 0; k < 4; k++)
                q.push_back('{lanes[k], 2'(k), last_of(cf[1:0], k)});
        end
        if (c && !exp_rdy) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n, input logic rdy);
        for (int unsigned k = 0; k < n; k++) step(1'b0, 3'b000, '0, '0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        m_ovf = 1'b0;
        rst = 1'b1; cap = 1'b0; cfg = '0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        out_ready = 1'b0; clr_ovf = 1'b0;
        #1;
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_data", out_data, '0);
        chk("rst_cap_ready", W'(cap_ready), 32'd1);
        chk("rst_ovf", W'(ovf), '0);
        #1 rst = 1'b0;

        // Single mode, capture on first edge after reset release
        step(1'b1, 3'b000, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Quad with 3 cycles of backpressure at beat 2
        step(1'b1, 3'b010, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1, 1'b0);
        idle(2, 1'b1);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Dual back-to-back, zero bubble
        step(1'b1, 3'b001, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b1, 3'b001, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Overrun at beat 1, then clear; then clear and overrun together
        step(1'b1, 3'b010, 32'h10, 32'h20, 32'h30, 32'h40, 1'b1, 1'b0);
        step(1'b0, 3'b000, '0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 3'b000, 32'hDEAD, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 3'b000, '0, '0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 3'b000, 32'h5, 32'h6, 32'h7, 32'h8, 1'b0, 1'b0);
        step(1'b1, 3'b000, 32'h9, 32'h9, 32'h9, 32'h9, 1'b0, 1'b1);
        idle(5, 1'b1);

        // Async reset in the middle of beat 2 with ovf set
        step(1'b1, 3'b010, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 1'b1, 1'b0);
        step(1'b1, 3'b000, 32'hBAD, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 3'b000, '0, '0, '0, '0, 1'b1, 1'b0);
        cap = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", W'(out_valid), '0);
        chk("mid_rst_ovf", W'(ovf), '0);
        chk("mid_rst_cap_ready", W'(cap_ready), 32'd1);
        chk("mid_rst_data", out_data, '0);
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        idle(1, 1'b1);
        step(1'b1, 3'b000, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b1, 1'b0);
        idle(5, 1'b1);

        // cfg=011 behaves as dual; live cfg changes do not matter
        step(1'b1, 3'b011, 32'h70, 32'h71, 32'h72, 32'h73, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            step(1'b0, 3'b010, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++)
            step(($urandom % 3) == 0, 3'($urandom), $urandom, $urandom, $urandom, $urandom,
                 ($urandom % 10) < 7, ($urandom % 10) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
